// File: rtl/sequenciador_execucao_pkg.sv
// Shared definitions for the execution sequencer: FSM state encodings and
// default timing constants used by the top level and benches.
package sequenciador_execucao_pkg;

  typedef enum logic [1:0] {
    PARADO         = 2'b00,
    EXECUTANDO     = 2'b01,
    ESPERA_ENTRADA = 2'b10,
    PARADO_HALT    = 2'b11
  } estado_e;

  localparam int DIV_RUN_PADRAO  = 25000000;
  localparam int DEBOUNCE_PADRAO = 50000;

endpackage

// File: rtl/sequenciador_execucao_debounce_botao.sv
// Push-button conditioning: 2-FF synchronizer, level debouncer and a one-shot
// pulse on each accepted press (stable 1 -> 0).
module debounce_botao
  import sequenciador_execucao_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO,
  parameter int DB_WIDTH        = 16
) (
  input  logic CLOCKAUTO,
  input  logic RESET,
  input  logic ENTER_N,
  output logic ENTER_PULSO
);

  localparam logic [DB_WIDTH-1:0] CNT_FIM = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                sinc1_q, sinc2_q;
  logic [1:0]          valido_q;
  logic                estavel_q, estavel_d;
  logic                armado_q, armado_d;
  logic                pulso_d;
  logic [DB_WIDTH-1:0] cnt_q, cnt_d;

  // A press is only honoured once the button has been seen released after
  // reset, so a button held through reset cannot fire a spurious pulse.
  always_comb begin
    cnt_d     = '0;
    estavel_d = estavel_q;
    pulso_d   = 1'b0;
    armado_d  = armado_q | (valido_q[1] & sinc2_q);
    if (sinc2_q != estavel_q) begin
      if (cnt_q == CNT_FIM) begin
        estavel_d = sinc2_q;
        pulso_d   = ~sinc2_q & armado_q;
      end else begin
        cnt_d = cnt_q + DB_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLOCKAUTO or posedge RESET) begin
    if (RESET) begin
      sinc1_q     <= 1'b1;
      sinc2_q     <= 1'b1;
      valido_q    <= 2'b00;
      estavel_q   <= 1'b1;
      armado_q    <= 1'b0;
      cnt_q       <= '0;
      ENTER_PULSO <= 1'b0;
    end else begin
      sinc1_q     <= ENTER_N;
      sinc2_q     <= sinc1_q;
      valido_q    <= {valido_q[0], 1'b1};
      estavel_q   <= estavel_d;
      armado_q    <= armado_d;
      cnt_q       <= cnt_d;
      ENTER_PULSO <= pulso_d;
    end
  end

endmodule

// File: rtl/sequenciador_execucao.sv
// Execution sequencer: turns the free-running board clock into a one-cycle
// commit enable for the core (run / single-step / input stall / halt).
module sequenciador_execucao
  import sequenciador_execucao_pkg::*;
#(
  parameter int DIV_RUN         = DIV_RUN_PADRAO,
  parameter int DIV_WIDTH       = 25,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO,
  parameter int DB_WIDTH        = 16
) (
  input  logic        CLOCKAUTO,
  input  logic        RESET,
  input  logic        ENTER_N,
  input  logic        MODO_RUN,
  input  logic        HALT,
  input  logic        PEDE_ENTRADA,
  output logic        CLOCK_EN,
  output logic        ENTRADA_OK,
  output logic        ENTER_PULSO,
  output logic [1:0]  ESTADO,
  output logic [31:0] CONTADOR_INSTR
);

  localparam logic [DIV_WIDTH-1:0] DIV_FIM = DIV_WIDTH'(DIV_RUN - 1);

  estado_e              estado_q, estado_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 clock_en_q, clock_en_d;
  logic                 entrada_ok_q, entrada_ok_d;
  logic [31:0]          contador_q, contador_d;
  logic                 enter_pulso;
  logic                 tick;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_WIDTH       (DB_WIDTH)
  ) u_debounce (
    .CLOCKAUTO  (CLOCKAUTO),
    .RESET      (RESET),
    .ENTER_N    (ENTER_N),
    .ENTER_PULSO(enter_pulso)
  );

  assign tick = (estado_q == EXECUTANDO) && (div_q == DIV_FIM);

  always_ff @(posedge CLOCKAUTO or posedge RESET) begin
    if (RESET) begin
      estado_q     <= PARADO;
      div_q        <= '0;
      clock_en_q   <= 1'b0;
      entrada_ok_q <= 1'b0;
      contador_q   <= '0;
    end else begin
      estado_q     <= estado_d;
      div_q        <= div_d;
      clock_en_q   <= clock_en_d;
      entrada_ok_q <= entrada_ok_d;
      contador_q   <= contador_d;
    end
  end

  // HALT overrides everything; PARADO_HALT is only left through RESET.
  always_comb begin
    estado_d = estado_q;
    if (HALT) begin
      estado_d = PARADO_HALT;
    end else begin
      case (estado_q)
        PARADO:         if (MODO_RUN) estado_d = EXECUTANDO;
        EXECUTANDO: begin
          if (!MODO_RUN)                estado_d = PARADO;
          else if (tick && PEDE_ENTRADA) estado_d = ESPERA_ENTRADA;
        end
        ESPERA_ENTRADA: if (enter_pulso) estado_d = MODO_RUN ? EXECUTANDO : PARADO;
        default:        estado_d = PARADO_HALT;
      endcase
    end
  end

  // Divider is held at zero outside EXECUTANDO, so every entry starts a full period.
  always_comb begin
    clock_en_d   = 1'b0;
    entrada_ok_d = 1'b0;
    div_d        = (estado_q == EXECUTANDO && !tick) ? div_q + DIV_WIDTH'(1) : '0;
    contador_d   = contador_q + 32'(clock_en_q);
    if (!HALT) begin
      case (estado_q)
        PARADO: begin
          if (!MODO_RUN && enter_pulso) begin
            clock_en_d   = 1'b1;
            entrada_ok_d = PEDE_ENTRADA;
          end
        end
        EXECUTANDO:     clock_en_d = MODO_RUN && tick && !PEDE_ENTRADA;
        ESPERA_ENTRADA: begin
          clock_en_d   = enter_pulso;
          entrada_ok_d = enter_pulso;
        end
        default: ;
      endcase
    end
  end

  assign CLOCK_EN       = clock_en_q;
  assign ENTRADA_OK     = entrada_ok_q;
  assign ENTER_PULSO    = enter_pulso;
  assign ESTADO         = estado_q;
  assign CONTADOR_INSTR = contador_q;

endmodule

// File: doc/sequenciador_execucao.md
Name: sequenciador_execucao

Overview:
- Execution sequencer for the single-cycle processor core.
- Generates a one-cycle advance enable (CLOCK_EN) for the program counter, register bank and data memory from the free-running board clock.
- Supports continuous run at a divided rate, single-step on a debounced button press, stall on input instructions until ENTER, and permanent stop on HALT.
- Sits between the board inputs (clock, button, mode switch) and the core, replacing the fixed clock divider.

Parameters:
- DIV_RUN, 25000000: board-clock cycles per instruction in run mode (>=2).
- DIV_WIDTH, 25: width of the run divider counter; must hold DIV_RUN-1.
- DEBOUNCE_CYCLES, 50000: consecutive equal samples required to accept a button level change (>=2).
- DB_WIDTH, 16: width of the debounce counter.

Ports:
- CLOCKAUTO  input  1  board clock; all logic on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ENTER_N  input  1  raw push-button, active-low, asynchronous to CLOCKAUTO.
- MODO_RUN  input  1  mode switch: 1 = continuous run, 0 = single-step.
- HALT  input  1  halt flag from the control unit, for the current instruction.
- PEDE_ENTRADA  input  1  current instruction reads switches and needs ENTER confirmation.
- CLOCK_EN  output  1  one-cycle pulse: core commits the current instruction.
- ENTRADA_OK  output  1  one-cycle pulse, coincident with CLOCK_EN, when an input instruction is committed.
- ENTER_PULSO  output  1  debounced one-shot press, for debug.
- ESTADO  output  2  FSM state: 00 PARADO, 01 EXECUTANDO, 10 ESPERA_ENTRADA, 11 PARADO_HALT.
- CONTADOR_INSTR  output  32  count of CLOCK_EN pulses since reset.

Behaviour:
- Reset (async, RESET=1):
  - ESTADO=PARADO.
  - CLOCK_EN, ENTRADA_OK, ENTER_PULSO and CONTADOR_INSTR are 0.
  - Divider is 0, debounce counter is 0, synchronizers and debounced level are "released" (1).
- Button path:
  - ENTER_N passes through a 2-FF synchronizer.
  - If the synchronized value differs from the stable level, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the new value and the counter clears.
  - ENTER_PULSO is 1 for exactly one cycle on a stable 1->0 transition.
  - Latency from raw press to pulse: 2 + DEBOUNCE_CYCLES cycles.
- Run divider:
  - Counts only in EXECUTANDO and clears on every entry to EXECUTANDO.
  - tick = (divider == DIV_RUN-1); the divider wraps to 0 on tick.
- All outputs are registered. A transition decided in cycle n appears on ESTADO and pulse outputs in cycle n+1.
- Highest priority, any state except PARADO_HALT: HALT=1 -> go to PARADO_HALT with no CLOCK_EN, even if a tick or press occurs in the same cycle.
- PARADO:
  - MODO_RUN=1 -> EXECUTANDO.
  - Otherwise a press -> one CLOCK_EN; ENTRADA_OK=1 as well if PEDE_ENTRADA=1. Stay in PARADO.
- EXECUTANDO:
  - MODO_RUN=0 -> PARADO with no pulse.
  - On tick with PEDE_ENTRADA=0 -> CLOCK_EN.
  - On tick with PEDE_ENTRADA=1 -> ESPERA_ENTRADA with no pulse.
  - Presses are ignored and not latched.
- ESPERA_ENTRADA:
  - A press -> CLOCK_EN and ENTRADA_OK. Next state is EXECUTANDO if MODO_RUN=1, else PARADO.
  - A MODO_RUN change alone does not leave this state.
- PARADO_HALT: terminal. No pulses; only RESET exits.
- CONTADOR_INSTR increments by 1 in the cycle after each CLOCK_EN and wraps from FFFFFFFF to 0.
- CLOCK_EN pulses are never adjacent. Minimum spacing is DIV_RUN cycles in run mode and one debounce period in step mode.
- Reset mid-press: the debouncer restarts. A button held through reset release produces no pulse until it is released and pressed again.

Decomposition:
- Shared package:
  - ESTADO encodings (PARADO, EXECUTANDO, ESPERA_ENTRADA, PARADO_HALT).
  - Default DIV_RUN and DEBOUNCE_CYCLES constants, also used by the top level and benches.
- One sub-module: debounce_botao.
  - Contains the synchronizer, debounce counter and one-shot.
  - Ports: CLOCKAUTO, RESET, ENTER_N -> ENTER_PULSO.
- The FSM, divider and instruction counter stay in sequenciador_execucao.

Test Plan:
- Bench parameters: DIV_RUN=4, DEBOUNCE_CYCLES=3.
- Run mode: RESET 1->0, MODO_RUN=1, HALT=0, PEDE_ENTRADA=0 for 20 cycles -> ESTADO=01; CLOCK_EN every 4th cycle, 4 pulses; CONTADOR_INSTR=4.
- Step mode: MODO_RUN=0; three clean presses held 10 cycles each, separated by 10 cycles -> exactly 3 CLOCK_EN; each pulse 2+3(+1 register) cycles after the falling edge; ENTER_PULSO count 3.
- Bounce: ENTER_N toggles every cycle for 8 cycles, then stays high -> no ENTER_PULSO and no CLOCK_EN.
- Input stall: run mode, PEDE_ENTRADA=1 at a tick -> ESTADO=10 and no pulses for 50 cycles; a press then gives CLOCK_EN=ENTRADA_OK=1 in the same cycle and ESTADO returns to 01.
- Halt priority: HALT=1 in the same cycle as a tick -> no CLOCK_EN, ESTADO=11; later presses and mode changes give no pulses; RESET -> ESTADO=00, CONTADOR_INSTR=0.
- Async reset: assert RESET mid-cycle while in ESPERA_ENTRADA with the button held -> outputs clear immediately; after release, no pulse until the button is released and pressed again.
